// File: rtl/instr_encoder_loader.sv
// Packs LW/SW/ADDI field bundles into RV32I words and writes them one by one into
// a word-indexed instruction memory, starting at BASE_ADDR after reset.
module instr_encoder_loader #(
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [1:0]        dbg_state
);

    // Handshake: a bundle transfers on a rising edge where in_valid and in_ready are
    // both high; in_ready is low outside IDLE, so the source must hold its bundle.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    localparam logic [1:0]      KIND_LW   = 2'b00;
    localparam logic [1:0]      KIND_SW   = 2'b01;
    localparam logic [1:0]      KIND_ADDI = 2'b10;
    localparam logic [ADDR_W:0] DEPTH_C   = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q;
    logic              in_ready_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [ADDR_W:0]   count_q;
    logic              full_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;

    logic [1:0]        kind_q;
    logic [4:0]        rd_q;
    logic [4:0]        rs1_q;
    logic [4:0]        rs2_q;
    logic [31:0]       imm_q;
    logic              last_q;

    logic [31:0]       wdata_d;
    logic [ADDR_W:0]   count_d;
    logic              imm_ok;

    // A 12-bit signed immediate fits only if bits 31..11 are a pure sign extension.
    assign imm_ok  = (&imm_q[31:11]) | ~(|imm_q[31:11]);
    assign count_d = count_q + (ADDR_W+1)'(1);

    always_comb begin
        wdata_d = mem_wdata_q;
        unique case (kind_q)
            KIND_LW:   wdata_d = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
            KIND_SW:   wdata_d = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
            KIND_ADDI: wdata_d = {imm_q[11:0], rs1_q, 3'b000, rd_q, 7'b0010011};
            default:   wdata_d = mem_wdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            kind_q      <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            last_q      <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        kind_q     <= in_kind;
                        rd_q       <= in_rd;
                        rs1_q      <= in_rs1;
                        rs2_q      <= in_rs2;
                        imm_q      <= in_imm;
                        last_q     <= in_last;
                        in_ready_q <= 1'b0;
                        state_q    <= S_ENC;
                    end
                end
                S_ENC: begin
                    // Illegal kind is reported ahead of a bad immediate.
                    if (kind_q == 2'b11) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else if (!imm_ok) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        mem_wdata_q <= wdata_d;
                        mem_we_q    <= 1'b1;
                        state_q     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    mem_addr_q <= mem_addr_q + ADDR_W'(1);
                    count_q    <= count_d;
                    done_q     <= last_q;
                    if (count_d == DEPTH_C) begin
                        full_q  <= 1'b1;
                        state_q <= S_FULL;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                S_FULL: begin
                    state_q <= S_FULL;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign full      = full_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader: a default-size instance and a 4-word
// instance share the field inputs; memory writes are scoreboarded against hand values.
module tb_instr_encoder_loader;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ENC   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_FULL  = 2'd3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid_a, in_valid_b;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready_a, mem_we_a, full_a, done_a, err_a;
    logic [7:0]  mem_addr_a;
    logic [31:0] mem_wdata_a;
    logic [8:0]  count_a;
    logic [1:0]  err_code_a, state_a;

    logic        in_ready_b, mem_we_b, full_b, done_b, err_b;
    logic [1:0]  mem_addr_b;
    logic [31:0] mem_wdata_b;
    logic [2:0]  count_b;
    logic [1:0]  err_code_b, state_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [39:0] exp_a_q[$];
    logic [39:0] exp_b_q[$];

    instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(8'd0)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
        .mem_wdata(mem_wdata_a), .count(count_a), .full(full_a), .done(done_a),
        .err(err_a), .err_code(err_code_a), .dbg_state(state_a)
    );

    instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(2'd0)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_last(in_last), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .count(count_b), .full(full_b), .done(done_b),
        .err(err_b), .err_code(err_code_b), .dbg_state(state_b)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a bundle and waits (bounded) until it is accepted; returns 1ns after the accepting edge.
    task automatic send(input int sel, input logic [1:0] kind, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [31:0] imm, input logic last, output bit ok);
        ok      = 1'b0;
        in_kind = kind;
        in_rd   = rd;
        in_rs1  = rs1;
        in_rs2  = rs2;
        in_imm  = imm;
        in_last = last;
        if (sel == 0) in_valid_a = 1'b1;
        else          in_valid_b = 1'b1;
        for (int c = 0; c < 20 && !ok; c++) begin
            if ((sel == 0) ? in_ready_a : in_ready_b) ok = 1'b1;
            step();
        end
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
    endtask

    // scoreboard: every write strobe must match the next expected {addr, word}
    always @(negedge clk) begin
        logic [39:0] e;
        if (mem_we_a) begin
            if (exp_a_q.size() == 0) check("a_unexpected_we", 1, 0);
            else begin
                e = exp_a_q.pop_front();
                check("a_we_addr", mem_addr_a, e[39:32]);
                check("a_we_data", mem_wdata_a, e[31:0]);
            end
        end
        if (mem_we_b) begin
            if (exp_b_q.size() == 0) check("b_unexpected_we", 1, 0);
            else begin
                e = exp_b_q.pop_front();
                check("b_we_addr", {6'd0, mem_addr_b}, e[39:32]);
                check("b_we_data", mem_wdata_b, e[31:0]);
            end
        end
    end

    initial begin
        bit ok;
        logic [31:0] b_words[4];
        b_words[0] = 32'h00002083;
        b_words[1] = 32'h00102083;
        b_words[2] = 32'h00202083;
        b_words[3] = 32'h00302083;

        reset = 1'b1;
        in_valid_a = 1'b0; in_valid_b = 1'b0;
        in_kind = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; in_last = 1'b0;
        repeat (3) step();

        check("rst_in_ready", in_ready_a, 1);
        check("rst_mem_we", mem_we_a, 0);
        check("rst_mem_addr", mem_addr_a, 0);
        check("rst_mem_wdata", mem_wdata_a, 0);
        check("rst_count", count_a, 0);
        check("rst_full", full_a, 0);
        check("rst_done", done_a, 0);
        check("rst_err", err_a, 0);
        check("rst_err_code", err_code_a, 0);
        check("rst_state", state_a, ST_IDLE);
        check("rst_b_in_ready", in_ready_b, 1);
        reset = 1'b0;
        step();

        // rejected bundles: imm out of range, then illegal kind (also out of range, with last)
        send(0, 2'b00, 5'd5, 5'd2, 5'd0, 32'd2048, 1'b0, ok);
        check("rej1_accept", ok, 1);
        check("rej1_state_enc", state_a, ST_ENC);
        check("rej1_ready_low", in_ready_a, 0);
        step();
        check("rej1_err", err_a, 1);
        check("rej1_err_code", err_code_a, 2'b01);
        check("rej1_state_idle", state_a, ST_IDLE);
        check("rej1_ready_back", in_ready_a, 1);
        check("rej1_count", count_a, 0);
        send(0, 2'b11, 5'd5, 5'd2, 5'd0, 32'd2048, 1'b1, ok);
        check("rej2_accept", ok, 1);
        step();
        check("rej2_err_code", err_code_a, 2'b10);
        check("rej2_done0", done_a, 0);
        step();
        check("rej2_done1", done_a, 0);
        check("rej2_count", count_a, 0);

        // LW rd=5 rs1=2 imm=-4 (rs2 set but ignored), latency check
        exp_a_q.push_back({8'd0, 32'hFFC12283});
        send(0, 2'b00, 5'd5, 5'd2, 5'd9, 32'hFFFF_FFFC, 1'b0, ok);
        check("lw_accept", ok, 1);
        check("lw_n1_we", mem_we_a, 0);
        step();
        check("lw_n2_we", mem_we_a, 1);
        check("lw_n2_state", state_a, ST_WRITE);
        check("lw_err_sticky", err_a, 1);
        check("lw_err_code_hold", err_code_a, 2'b10);
        step();
        check("lw_n3_we", mem_we_a, 0);
        check("lw_count", count_a, 1);
        check("lw_addr_inc", mem_addr_a, 1);
        check("lw_ready", in_ready_a, 1);
        check("lw_wdata_hold", mem_wdata_a, 32'hFFC12283);

        // SW (rd ignored), ADDI at both immediate bounds
        exp_a_q.push_back({8'd1, 32'h0271A423});
        send(0, 2'b01, 5'd31, 5'd3, 5'd7, 32'd40, 1'b0, ok);
        check("sw_accept", ok, 1);
        exp_a_q.push_back({8'd2, 32'h7FF00093});
        send(0, 2'b10, 5'd1, 5'd0, 5'd31, 32'd2047, 1'b0, ok);
        check("addi_max_accept", ok, 1);
        exp_a_q.push_back({8'd3, 32'h80020193});
        send(0, 2'b10, 5'd3, 5'd4, 5'd0, 32'hFFFF_F800, 1'b0, ok);
        check("addi_min_accept", ok, 1);
        step(); step();
        check("bounds_count", count_a, 4);
        check("bounds_err_code", err_code_a, 2'b10);

        // three bundles, last one flagged: done pulses once, after the 3rd write
        for (int i = 0; i < 3; i++) begin
            exp_a_q.push_back({8'(4 + i), 32'h00110113});
            send(0, 2'b10, 5'd2, 5'd2, 5'd0, 32'd1, (i == 2), ok);
            check("prog_accept", ok, 1);
            step();
            check("prog_we", mem_we_a, 1);
            check("prog_done_early", done_a, 0);
            step();
            check("prog_done", done_a, (i == 2));
            if (i == 2) begin
                step();
                check("prog_done_off", done_a, 0);
            end
        end

        // reset while in WRITE
        exp_a_q.push_back({8'd7, 32'hFFC12283});
        send(0, 2'b00, 5'd5, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0, ok);
        check("rstw_accept", ok, 1);
        step();
        check("rstw_in_write", state_a, ST_WRITE);
        reset = 1'b1;
        step();
        check("rstw_we", mem_we_a, 0);
        check("rstw_count", count_a, 0);
        check("rstw_addr", mem_addr_a, 0);
        check("rstw_state", state_a, ST_IDLE);
        check("rstw_err", err_a, 0);
        check("rstw_ready", in_ready_a, 1);
        reset = 1'b0;
        exp_a_q.push_back({8'd0, 32'h00002083});
        send(0, 2'b00, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, ok);
        check("post_rst_accept", ok, 1);
        step(); step();
        check("post_rst_count", count_a, 1);
        check("post_rst_addr", mem_addr_a, 1);

        // 4-word instance: fills, then refuses the 5th bundle
        for (int i = 0; i < 4; i++) begin
            exp_b_q.push_back({8'(i), b_words[i]});
            send(1, 2'b00, 5'd1, 5'd0, 5'd0, 32'(i), 1'b0, ok);
            check("b_accept", ok, 1);
        end
        step(); step();
        check("b_full", full_b, 1);
        check("b_ready_low", in_ready_b, 0);
        check("b_count", count_b, 4);
        check("b_state", state_b, ST_FULL);
        check("b_addr_wrap", mem_addr_b, 0);
        send(1, 2'b00, 5'd1, 5'd0, 5'd0, 32'd4, 1'b0, ok);
        check("b_5th_refused", ok, 0);
        check("b_count_after", count_b, 4);
        check("b_state_after", state_b, ST_FULL);

        step(); step();
        check("a_exp_drained", exp_a_q.size(), 0);
        check("b_exp_drained", exp_b_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
